// File: rtl/decoder3_8_strobe_pkg.sv
// Shared encodings and widths for the 3:8 strobe decoder and its helpers.
package decoder3_8_strobe_pkg;

  localparam int OH_W   = 8;
  localparam int CODE_W = 3;

  // 2'd3 is unused; the FSM falls back to IDLE if it ever appears.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  function automatic int cnt_w(input int hold, input int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/decoder3_8_strobe_onehot.sv
// Pure combinational 3-bit code to 8-bit one-hot decode.
module onehot_dec3_8
  import decoder3_8_strobe_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic [OH_W-1:0]   oh_o
);

  always_comb begin
    oh_o         = '0;
    oh_o[code_i] = 1'b1;
  end

endmodule

// File: rtl/decoder3_8_strobe.sv
// Registered 3:8 one-hot strobe: accept a code, hold y for HOLD_CYCLES,
// then force GAP_CYCLES idle clocks before the next accept.
module decoder3_8_strobe
  import decoder3_8_strobe_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] code,
  output logic              in_ready,
  output logic [OH_W-1:0]   y,
  output logic              busy,
  output logic              done
);

  localparam int CW = cnt_w(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [OH_W-1:0]     y_q, y_d;
  logic                done_q, done_d;
  logic [OH_W-1:0]     oh;
  logic                accept;

  // Decode the code that will be held next cycle, so y tracks code_q.
  onehot_dec3_8 u_dec (
    .code_i (code_d),
    .oh_o   (oh)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      y_q     <= y_d;
      done_q  <= done_d;
    end
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    y_d     = '0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_DRIVE;
          cnt_d   = HOLD_LD;
          code_d  = code;
          y_d     = oh;
        end
      end
      ST_DRIVE: begin
        // Enable wins over the counter: an abort on the last hold clock skips done.
        if (!en) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
          y_d   = oh;
        end else begin
          done_d = 1'b1;
          if (GAP_CYCLES > 0) begin
            state_d = ST_GAP;
            cnt_d   = GAP_LD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (!en) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    in_ready = en && (state_q == ST_IDLE);
    busy     = (state_q != ST_IDLE);
    y        = y_q;
    done     = done_q;
  end

endmodule

// File: tb/tb_decoder3_8_strobe.sv
// Directed table-driven bench for decoder3_8_strobe: default, HOLD=1/GAP=0 and HOLD=16 builds.
module tb_decoder3_8_strobe;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [2:0]      en_s, v_s, rdy_s, busy_s, done_s;
  logic [2:0][2:0] code_s;
  logic [2:0][7:0] y_s;

  always #5 clk = ~clk;

  decoder3_8_strobe u_def (
    .clk(clk), .rst_n(rst_n), .en(en_s[0]), .in_valid(v_s[0]), .code(code_s[0]),
    .in_ready(rdy_s[0]), .y(y_s[0]), .busy(busy_s[0]), .done(done_s[0]));

  decoder3_8_strobe #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) u_h1 (
    .clk(clk), .rst_n(rst_n), .en(en_s[1]), .in_valid(v_s[1]), .code(code_s[1]),
    .in_ready(rdy_s[1]), .y(y_s[1]), .busy(busy_s[1]), .done(done_s[1]));

  decoder3_8_strobe #(.HOLD_CYCLES(16), .GAP_CYCLES(1)) u_h16 (
    .clk(clk), .rst_n(rst_n), .en(en_s[2]), .in_valid(v_s[2]), .code(code_s[2]),
    .in_ready(rdy_s[2]), .y(y_s[2]), .busy(busy_s[2]), .done(done_s[2]));

  typedef struct {
    int         sel;
    logic       en;
    logic       v;
    logic [2:0] code;
    logic [7:0] y;
    logic       busy;
    logic       done;
    logic       rdy;
    string      name;
  } vec_t;

  vec_t vq[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic void add(input int sel, input logic en, input logic v, input logic [2:0] c,
                              input logic [7:0] y, input logic b, input logic d, input logic r,
                              input string name);
    vec_t t;
    t.sel = sel; t.en = en; t.v = v; t.code = c;
    t.y = y; t.busy = b; t.done = d; t.rdy = r; t.name = name;
    vq.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got y/busy/done/rdy=%h required %h", name, act, exp);
  endtask

  // Each row: drive on the falling edge, sample 1ns later, rising edge follows.
  task automatic run_table();
    foreach (vq[i]) begin
      @(negedge clk);
      en_s = 3'b111; v_s = 3'b000; code_s = '0;
      en_s[vq[i].sel]   = vq[i].en;
      v_s[vq[i].sel]    = vq[i].v;
      code_s[vq[i].sel] = vq[i].code;
      #1;
      chk($sformatf("%s[%0d]", vq[i].name, i),
          {y_s[vq[i].sel], busy_s[vq[i].sel], done_s[vq[i].sel], rdy_s[vq[i].sel]},
          {vq[i].y, vq[i].busy, vq[i].done, vq[i].rdy});
    end
    vq.delete();
  endtask

  task automatic add_basic(input string nm);
    add(0, 1, 1, 3'd5, 8'h00, 0, 0, 1, nm);
    for (int k = 0; k < 4; k++) add(0, 1, 0, 3'd0, 8'h20, 1, 0, 0, nm);
    add(0, 1, 0, 3'd0, 8'h00, 1, 1, 0, nm);
    add(0, 1, 0, 3'd0, 8'h00, 0, 0, 1, nm);
  endtask

  initial begin
    en_s = '0; v_s = '0; code_s = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++)
      chk($sformatf("reset_state%0d", d), {y_s[d], busy_s[d], done_s[d], 1'b0}, 11'h0);
    rst_n = 1'b1;
    en_s  = 3'b111;

    add_basic("basic");

    // All codes back to back, in_valid held high: accepts 6 clocks apart.
    for (int c = 0; c < 8; c++) begin
      add(0, 1, 1, 3'(c), 8'h00, 0, 0, 1, "allcodes");
      for (int k = 0; k < 4; k++) add(0, 1, 1, 3'(c), 8'(1 << c), 1, 0, 0, "allcodes");
      add(0, 1, 1, 3'(c), 8'h00, 1, 1, 0, "allcodes");
    end

    // Code/valid churn while busy must be ignored.
    add(0, 1, 1, 3'd1, 8'h00, 0, 0, 1, "ignore");
    add(0, 1, 0, 3'd6, 8'h02, 1, 0, 0, "ignore");
    add(0, 1, 1, 3'd7, 8'h02, 1, 0, 0, "ignore");
    add(0, 1, 0, 3'd0, 8'h02, 1, 0, 0, "ignore");
    add(0, 1, 1, 3'd5, 8'h02, 1, 0, 0, "ignore");
    add(0, 1, 1, 3'd4, 8'h00, 1, 1, 0, "ignore");
    add(0, 1, 0, 3'd0, 8'h00, 0, 0, 1, "ignore");

    // Abort on the 2nd drive clock; in_ready stays low until en returns.
    add(0, 1, 1, 3'd2, 8'h00, 0, 0, 1, "abort");
    add(0, 1, 0, 3'd0, 8'h04, 1, 0, 0, "abort");
    add(0, 0, 0, 3'd0, 8'h04, 1, 0, 0, "abort");
    add(0, 0, 0, 3'd0, 8'h00, 0, 0, 0, "abort");
    add(0, 0, 1, 3'd3, 8'h00, 0, 0, 0, "abort");
    add(0, 1, 0, 3'd0, 8'h00, 0, 0, 1, "abort");

    // Abort on the final hold clock: no done.
    add(0, 1, 1, 3'd6, 8'h00, 0, 0, 1, "abort_last");
    for (int k = 0; k < 3; k++) add(0, 1, 0, 3'd0, 8'h40, 1, 0, 0, "abort_last");
    add(0, 0, 0, 3'd0, 8'h40, 1, 0, 0, "abort_last");
    add(0, 1, 0, 3'd0, 8'h00, 0, 0, 1, "abort_last");

    // HOLD=1, GAP=0: accept every 2 clocks, done alongside the next accept.
    add(1, 1, 1, 3'd0, 8'h00, 0, 0, 1, "h1");
    add(1, 1, 1, 3'd1, 8'h01, 1, 0, 0, "h1");
    add(1, 1, 1, 3'd1, 8'h00, 0, 1, 1, "h1");
    add(1, 1, 1, 3'd2, 8'h02, 1, 0, 0, "h1");
    add(1, 1, 0, 3'd0, 8'h00, 0, 1, 1, "h1");
    add(1, 1, 0, 3'd0, 8'h00, 0, 0, 1, "h1");

    // HOLD=16: wide counter holds exactly 16 clocks.
    add(2, 1, 1, 3'd3, 8'h00, 0, 0, 1, "h16");
    for (int k = 0; k < 16; k++) add(2, 1, 0, 3'd0, 8'h08, 1, 0, 0, "h16");
    add(2, 1, 0, 3'd0, 8'h00, 1, 1, 0, "h16");
    add(2, 1, 0, 3'd0, 8'h00, 0, 0, 1, "h16");

    run_table();

    // Async reset between edges while y=80.
    @(negedge clk);
    en_s = 3'b111; v_s = 3'b001; code_s[0] = 3'd7;
    @(negedge clk);
    v_s = '0;
    @(negedge clk);
    chk("pre_reset_y", {y_s[0], busy_s[0], done_s[0], rdy_s[0]}, {8'h80, 1'b1, 1'b0, 1'b0});
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset", {y_s[0], busy_s[0], done_s[0], 1'b0}, 11'h0);
    @(negedge clk);
    rst_n = 1'b1;

    add_basic("post_reset");
    run_table();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
